fp_dot_seq: RTL and testbench
=============================

Name: fp_dot_seq

Overview:
- Sequencer that streams vector element pairs through one combinational floating-point MAC (mac_out = in_a*in_b + in_c).
- Feeds the MAC's in_c from an internal accumulator register, so a length-N dot product is computed one element per cycle.
- Sits between an operand streamer and a result consumer; valid/ready handshakes on both sides, start/abort control.

Parameters:
- BIT_WIDTH, 16, total FP word width
- EXP_WIDTH, 8, exponent width (bfloat16 default)
- MANT_WIDTH, 7, mantissa width
- TRUNC_MANTISSA_MBM_BITS, 0, mantissa truncation passed unchanged to the MAC
- LEN_WIDTH, 9, width of vector-length field (max length 2^LEN_WIDTH-1)

Ports:
- clk, input, 1, single clock; all state updates on rising edge
- rst, input, 1, asynchronous, active-high reset
- start, input, 1, begin job; sampled only in IDLE
- len, input, LEN_WIDTH, element count; captured on accepted start
- init_acc, input, BIT_WIDTH, accumulator seed; captured on accepted start
- abort, input, 1, synchronous cancel, any state
- busy, output, 1, high in any state other than IDLE
- in_valid, input, 1, operand pair valid
- in_ready, output, 1, sequencer accepts operand pair
- in_a, input, BIT_WIDTH, multiplier operand 1
- in_b, input, BIT_WIDTH, multiplier operand 2
- out_valid, output, 1, result valid
- out_ready, input, 1, consumer accepts result
- out_data, output, BIT_WIDTH, dot-product result

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, cnt=0, len_q=0; busy=0, in_ready=0, out_valid=0, out_data=0.
- Beat = in_valid & in_ready. Result handshake = out_valid & out_ready.
- IDLE: in_ready=0, out_valid=0.
  - start & len!=0: acc<=init_acc, len_q<=len, cnt<=0, go to ACCUM.
  - start & len==0: acc<=init_acc, go to DONE (result = init_acc; out_valid the next cycle).
- ACCUM: in_ready=1.
  - On a beat: acc<=mac_out, computed from (in_a, in_b, acc); cnt<=cnt+1.
  - If cnt==len_q-1 at the beat, go to DONE.
  - No beat: hold everything.
- DONE: out_valid=1, out_data=acc (stable while out_ready=0). On result handshake, go to IDLE.
- out_data is driven from acc in every state; it is meaningful only while out_valid=1.
- start outside IDLE is ignored; len/init_acc changes after capture have no effect.
- abort=1 in any state: next state IDLE, acc/cnt cleared, no result produced. abort has priority over start, beat and result handshake in the same cycle.
- Latency: out_valid rises the cycle after the final beat. Throughput is 1 element/cycle.
- Rounding, exceptions and special values are exactly those of the MAC. The MAC's exception/overflow flags are not exported.
- cnt is LEN_WIDTH bits and never wraps, because len_q ≤ 2^LEN_WIDTH-1.

Optional Feature:
- Macro: FP_DOT_SEQ_MAC_PIPE_REG_EN.
- Defined:
  - A register (mac_q) captures mac_out on each beat.
  - ACCUM moves to a WAIT state after every beat; in WAIT, in_ready=0 and acc<=mac_q.
  - WAIT returns to ACCUM, or to DONE after the final element.
  - Throughput is 1 element per 2 cycles; out_valid rises 2 cycles after the final beat.
  - abort in WAIT behaves as in any other state.
- Undefined: no mac_q and no WAIT state; behaviour exactly as above.

Decomposition:
- Shared package fp_mac_pkg:
  - state enum (IDLE, ACCUM, WAIT, DONE)
  - format constants for FP32/BF16/FP16 (sign/exp/mant widths)
  - constants FP_ZERO and BF16_ONE (16'h3F80)
- One sub-module: the existing mac_unit, instantiated once with parameters passed through. There is no other sub-module; the FSM, counter and accumulator stay in fp_dot_seq.

Test Plan:
- BF16 dot product: init_acc=0x0000, len=2, beats (0x3F80,0x4000) then (0x4000,0x4040). Required: out_data=0x4100 (8.0), out_valid exactly 1 cycle after the 2nd beat (2 cycles with the PIPE macro).
- Zero length: len=0, init_acc=0x3F80, start. Required: no in_ready, out_valid next cycle, out_data=0x3F80.
- Backpressure: len=1, beat (0x4040,0x4000), out_ready held low 5 cycles. Required: out_valid=1 and out_data=0x40C0 stable all 5 cycles; IDLE the cycle after out_ready=1.
- Input stalls and ignored start: len=3 with in_valid gaps of 2 cycles, start pulsed mid-job. Required: cnt advances only on beats, the job is not restarted, and the result equals the gap-free run.
- Abort mid-job: abort after the 1st of 4 beats. Required: busy=0 next cycle, no out_valid ever for that job; the following start with init_acc=0x3F00 and len=1, beat (0x3F80,0x3F80), gives 0x3FC0.
- Async reset: assert rst in DONE between clock edges. Required: out_valid=0, busy=0, out_data=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Types and format constants shared by the dot-product sequencer and its MAC.
package fp_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FP32_SIGN_W = 1;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_MANT_W = 23;
    localparam int BF16_SIGN_W = 1;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_MANT_W = 7;
    localparam int FP16_SIGN_W = 1;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MANT_W = 10;

    localparam logic [15:0] FP_ZERO  = 16'h0000;
    localparam logic [15:0] BF16_ONE = 16'h3F80;

endpackage

// File: rtl/mac_unit.sv
// Combinational fused multiply-add: mac_out = in_a*in_b + in_c, round-to-nearest-even.
// Subnormals are flushed to zero; NaN results are a single canonical quiet NaN.
module mac_unit #(
    parameter int BIT_WIDTH               = 16,
    parameter int EXP_WIDTH               = 8,
    parameter int MANT_WIDTH              = 7,
    parameter int TRUNC_MANTISSA_MBM_BITS = 0
) (
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic [BIT_WIDTH-1:0] in_c,
    output logic [BIT_WIDTH-1:0] mac_out
);
    localparam int M    = MANT_WIDTH;
    localparam int PW   = 2 * (M + 1);
    localparam int XW   = 2 * PW + 1;
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int EMAX = (1 << EXP_WIDTH) - 1;
    localparam logic [M-1:0] TMASK = {M{1'b1}} << TRUNC_MANTISSA_MBM_BITS;

    logic                 sa, sb, sc, sp, sr, za, zb, zc, ia, ib, ic, na, nb, nc;
    logic [EXP_WIDTH-1:0] ea, eb, ec;
    logic [M-1:0]         fa, fb, fc, mant;
    logic [PW-1:0]        mp, mc;
    logic [XW-1:0]        xp, xc, r, norm;
    logic                 guard, sticky, lost, carry;
    int                   ep, ecx, emx, d, p, e_res;

    always_comb begin
        {sa, ea, fa} = in_a;
        {sb, eb, fb} = in_b;
        {sc, ec, fc} = in_c;
        za = (ea == '0);  zb = (eb == '0);  zc = (ec == '0);
        ia = (ea == '1) && (fa == '0);  na = (ea == '1) && (fa != '0);
        ib = (eb == '1) && (fb == '0);  nb = (eb == '1) && (fb != '0);
        ic = (ec == '1) && (fc == '0);  nc = (ec == '1) && (fc != '0);
        sp = sa ^ sb;

        // Both significands carry 2M fraction bits so product and addend share a scale.
        mp  = PW'({1'b1, fa & TMASK}) * PW'({1'b1, fb & TMASK});
        mc  = PW'({1'b1, fc}) << M;
        ep  = int'(ea) + int'(eb) - BIAS;
        ecx = zc ? ep : int'(ec);
        xp  = {1'b0, mp, {PW{1'b0}}};
        xc  = zc ? '0 : {1'b0, mc, {PW{1'b0}}};

        emx  = (ep >= ecx) ? ep : ecx;
        d    = (ep >= ecx) ? ep - ecx : ecx - ep;
        lost = 1'b0;
        if (ep >= ecx) begin
            if (d >= XW) begin lost = |xc; xc = '0; end
            else begin lost = |(xc & ((XW'(1) << d) - XW'(1))); xc = xc >> d; end
            xc[0] = xc[0] | lost;
        end else begin
            if (d >= XW) begin lost = |xp; xp = '0; end
            else begin lost = |(xp & ((XW'(1) << d) - XW'(1))); xp = xp >> d; end
            xp[0] = xp[0] | lost;
        end

        if (sp == sc)     begin r = xp + xc; sr = sp; end
        else if (xp >= xc) begin r = xp - xc; sr = sp; end
        else              begin r = xc - xp; sr = sc; end

        p = 0;
        for (int i = 0; i < XW; i++) if (r[i]) p = i;
        e_res  = p + emx - 2 * M - PW;
        norm   = r << (XW - 1 - p);
        mant   = norm[XW-2 -: M];
        guard  = norm[XW-2-M];
        sticky = |norm[XW-3-M:0];
        {carry, mant} = {1'b0, mant} + (M+1)'(guard & (sticky | mant[0]));
        if (carry) e_res = e_res + 1;

        if (na || nb || nc || ((ia || ib) && (za || zb)) || ((ia || ib) && ic && (sp != sc)))
            mac_out = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(M-1){1'b0}}};
        else if (ia || ib)
            mac_out = {sp, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
        else if (ic)
            mac_out = {sc, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
        else if (za || zb)
            mac_out = zc ? {sp & sc, {(BIT_WIDTH-1){1'b0}}} : in_c;
        else if (r == '0)
            mac_out = '0;
        else if (e_res >= EMAX)
            mac_out = {sr, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
        else if (e_res <= 0)
            mac_out = {sr, {(BIT_WIDTH-1){1'b0}}};
        else
            mac_out = {sr, EXP_WIDTH'(e_res), mant};
    end
endmodule

// File: rtl/fp_dot_seq.sv
// Streams element pairs through one MAC, accumulating a dot product of length len.
// Define FP_DOT_SEQ_MAC_PIPE_REG_EN to register the MAC output (one element per 2 cycles).
module fp_dot_seq
    import fp_mac_pkg::*;
#(
    parameter int BIT_WIDTH               = 16,
    parameter int EXP_WIDTH               = 8,
    parameter int MANT_WIDTH              = 7,
    parameter int TRUNC_MANTISSA_MBM_BITS = 0,
    parameter int LEN_WIDTH               = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [BIT_WIDTH-1:0] init_acc,
    input  logic                 abort,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data
);
    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] acc_q, acc_d, mac_out;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
`ifdef FP_DOT_SEQ_MAC_PIPE_REG_EN
    logic [BIT_WIDTH-1:0] mac_q, mac_d;
`endif

    mac_unit #(
        .BIT_WIDTH              (BIT_WIDTH),
        .EXP_WIDTH              (EXP_WIDTH),
        .MANT_WIDTH             (MANT_WIDTH),
        .TRUNC_MANTISSA_MBM_BITS(TRUNC_MANTISSA_MBM_BITS)
    ) u_mac (
        .in_a   (in_a),
        .in_b   (in_b),
        .in_c   (acc_q),
        .mac_out(mac_out)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef FP_DOT_SEQ_MAC_PIPE_REG_EN
        mac_d     = mac_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                acc_d = init_acc;
                if (len != '0) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = DONE;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
`ifdef FP_DOT_SEQ_MAC_PIPE_REG_EN
                    mac_d   = mac_out;
                    state_d = WAIT;
`else
                    acc_d = mac_out;
                    if (cnt_q == len_q - LEN_WIDTH'(1)) state_d = DONE;
`endif
                end
            end
`ifdef FP_DOT_SEQ_MAC_PIPE_REG_EN
            // cnt already counts the element just multiplied.
            WAIT: begin
                acc_d   = mac_q;
                state_d = (cnt_q == len_q) ? DONE : ACCUM;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef FP_DOT_SEQ_MAC_PIPE_REG_EN
            mac_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef FP_DOT_SEQ_MAC_PIPE_REG_EN
            mac_q   <= mac_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign out_data = acc_q;

endmodule

// File: tb/tb_fp_dot_seq.sv
// Scoreboard bench for fp_dot_seq: expected results queued at job start, popped on result handshake.
module tb_fp_dot_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [8:0]  len = '0;
    logic [15:0] init_acc = '0, in_a = '0, in_b = '0;
    logic        busy, in_ready, out_valid;
    logic [15:0] out_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] sb_q[$];

`ifdef FP_DOT_SEQ_MAC_PIPE_REG_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    fp_dot_seq dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .init_acc(init_acc),
        .abort(abort), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [8:0] l, input logic [15:0] init);
        start = 1'b1; len = l; init_acc = init;
        step();
        start = 1'b0; len = 9'h1AA; init_acc = 16'hDEAD;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && n < 20) begin step(); n++; end
        if (!in_ready) chk("beat_ready_timeout", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0; in_a = 16'hBAD0; in_b = 16'hBAD0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin step(); n++; end
        chk(tag, {31'b0, out_valid}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("unexpected_result", {16'b0, out_data}, 32'hFFFF_FFFF);
            else                  chk("result", {16'b0, out_data}, {16'b0, sb_q.pop_front()});
        end
    end

    initial begin
        #1;
        chk("rst_busy",      {31'b0, busy},      0);
        chk("rst_in_ready",  {31'b0, in_ready},  0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data",  {16'b0, out_data},  0);
        step(); step();
        rst = 1'b0;
        step();

        // 1*2 + 2*3 = 8.0
        out_ready = 1'b1;
        sb_q.push_back(16'h4100);
        go(9'd2, 16'h0000);
        beat(16'h3F80, 16'h4000);
        beat(16'h4000, 16'h4040);
        if (PIPE) begin
            chk("dot_lat_pre", {31'b0, out_valid}, 0);
            step();
        end
        chk("dot_latency", {31'b0, out_valid}, 1);
        step();
        chk("dot_idle", {31'b0, busy}, 0);

        // zero length
        out_ready = 1'b0;
        go(9'd0, 16'h3F80);
        chk("zl_valid",    {31'b0, out_valid}, 1);
        chk("zl_in_ready", {31'b0, in_ready},  0);
        chk("zl_data",     {16'b0, out_data},  32'h3F80);
        sb_q.push_back(16'h3F80);
        out_ready = 1'b1;
        step();
        chk("zl_idle", {31'b0, busy}, 0);

        // backpressure: 3*2 = 6.0 held for 5 cycles
        out_ready = 1'b0;
        go(9'd1, 16'h0000);
        beat(16'h4040, 16'h4000);
        wait_valid("bp_valid_rise");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {31'b0, out_valid}, 1);
            chk("bp_hold_data",  {16'b0, out_data},  32'h40C0);
            step();
        end
        sb_q.push_back(16'h40C0);
        out_ready = 1'b1;
        step();
        chk("bp_idle", {31'b0, busy}, 0);

        // gap-free reference: 1*1 + 2*2 + 3*1 = 8.0
        sb_q.push_back(16'h4100);
        go(9'd3, 16'h0000);
        beat(16'h3F80, 16'h3F80);
        beat(16'h4000, 16'h4000);
        beat(16'h4040, 16'h3F80);
        wait_valid("ref_valid");
        step();

        // same job with stalls and a stray start
        sb_q.push_back(16'h4100);
        go(9'd3, 16'h0000);
        beat(16'h3F80, 16'h3F80);
        step();
        start = 1'b1; len = 9'd1; init_acc = 16'h3F80;
        step();
        start = 1'b0;
        chk("stall_busy", {31'b0, busy}, 1);
        beat(16'h4000, 16'h4000);
        step(); step();
        chk("stall_no_early_result", {31'b0, out_valid}, 0);
        beat(16'h4040, 16'h3F80);
        wait_valid("stall_valid");
        step();

        // abort after first of 4 beats
        go(9'd4, 16'h0000);
        beat(16'h3F80, 16'h3F80);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_valid", {31'b0, out_valid}, 0);
            step();
        end
        sb_q.push_back(16'h3FC0);
        go(9'd1, 16'h3F00);
        beat(16'h3F80, 16'h3F80);
        wait_valid("post_abort_valid");
        step();

        // async reset while in DONE
        out_ready = 1'b0;
        go(9'd0, 16'h4000);
        chk("ar_pre_valid", {31'b0, out_valid}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 0);
        chk("ar_busy",  {31'b0, busy},      0);
        chk("ar_data",  {16'b0, out_data},  0);
        step();
        rst = 1'b0;
        step();

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
